nexys_starship_spawn_ctrl: RTL and testbench
============================================

Name: nexys_starship_spawn_ctrl

Overview:
- Central spawn scheduler for the four monster lanes (left, right, top, bottom = bits 0..3).
- Paces spawns on the game timer tick and picks a pseudo-random empty lane, capping concurrent monsters by difficulty level.
- Drives each lane's `*_random` input one-hot and raises difficulty as spawns accumulate.
- Sits between the top-level game controller (`play_flag`, `gameover_ctrl`) and the per-lane monster modules.

Parameters:
- `LFSR_SEED`, 16'hACE1: LFSR reset value; must be nonzero.
- `BASE_INTERVAL`, 8: ticks between spawn attempts at level 0.
- `MIN_INTERVAL`, 3: interval floor.
- `INTERVAL_STEP`, 1: ticks removed per level.
- `SPAWNS_PER_LEVEL`, 6: granted spawns per level increment.
- `MAX_LEVEL`, 7: level saturation value.
- `GRANT_TIMEOUT`, 64: Clk cycles a grant is held without acknowledgement before it is abandoned.

Ports:
- `Clk` input 1: system clock.
- `Reset` input 1: asynchronous, active-low reset.
- `timer_tick` input 1: one-Clk-wide pulse at game timer rate.
- `play_flag` input 1: game start request.
- `gameover_ctrl` input 1: game over from top level.
- `lane_full` input 4: per-lane monster-present flags.
- `lane_random` output 4: one-hot spawn grant per lane.
- `level` output 4: current difficulty level.
- `active_count` output 3: number of set bits in `lane_full`.
- `q_Idle`, `q_Wait`, `q_Grant`, `q_Halt` output 1 each: one-hot state indicators.

Behaviour:
- **Reset (Reset=0, async).** State=IDLE, `lane_random`=0, `level`=0, LFSR=`LFSR_SEED`, interval counter=0, spawn counter=0, grant timer=0. Resets mid-grant abort immediately.
- **LFSR.**
  - 16-bit Galois, taps x^16+x^14+x^13+x^11.
  - Advances every Clk in every state except IDLE.
  - Never reaches zero; if zero is ever detected, it reloads `LFSR_SEED`.
- **Derived values (combinational).**
  - `active_count` = popcount(`lane_full`).
  - `max_active` = min(4, `level`+1).
  - `interval` = max(`MIN_INTERVAL`, `BASE_INTERVAL` − `level`*`INTERVAL_STEP`), 8-bit, saturating; no underflow wrap.
- **IDLE.**
  - Outputs 0; counters cleared.
  - `play_flag`=1 → WAIT next Clk.
- **WAIT.**
  - Interval counter increments on each `timer_tick`.
  - When counter+1 = `interval` on a tick, the counter clears and a pick is evaluated in that same Clk.
  - Pick: candidate c = LFSR[1:0]. Search lanes c, c+1, c+2, c+3 (mod 4) for the first with `lane_full`=0.
  - If a lane is found and `active_count` < `max_active`: latch lane L, set `lane_random`=onehot(L), go to GRANT.
  - Otherwise stay in WAIT with the counter cleared (attempt skipped; no grant).
- **GRANT.**
  - `lane_random` held at onehot(L); grant timer counts Clk cycles.
  - Exit when `lane_full[L]` rises (acknowledged spawn): `lane_random`→0 next Clk, spawn counter++, go to WAIT.
  - When spawn counter reaches `SPAWNS_PER_LEVEL`: counter→0, `level`++ (saturate at `MAX_LEVEL`).
  - Grant timer reaching `GRANT_TIMEOUT`−1 without ack: `lane_random`→0, go to WAIT, no spawn counted.
  - Only one lane is ever granted at a time.
- **HALT.**
  - Entered from WAIT or GRANT when `gameover_ctrl`=1. `gameover_ctrl` has priority over ack and timeout in the same Clk.
  - `lane_random`=0; `level` and counters frozen.
  - `play_flag`=0 and `gameover_ctrl`=0 → IDLE, where `level` is cleared.
- **Timing.**
  - All outputs are registered; `lane_random` changes one Clk after the deciding event.
  - `timer_tick` arriving in GRANT is ignored (no counting while a grant is outstanding).
- **Invalid state encoding** → IDLE.

Test Plan:
1. **Reset and start.** Reset=0 → all outputs 0, `q_Idle`=1. Release, `play_flag`=1 → `q_Wait`=1 next Clk; `lane_random` stays 0 for the first 7 ticks and is one-hot after the 8th tick at level 0.
2. **Ack and level-up.** Grant lane L, raise `lane_full[L]` 3 Clks later → `lane_random`=0 the Clk after. After 6 acknowledged spawns → `level`=1, `interval`=7 ticks.
3. **Occupancy cap and skip.** With `lane_full`=4'b0001 at level 0 (`max_active`=1), the attempt is skipped and `lane_random` stays 0. With `lane_full`=4'b1111 at level 3, no grant.
4. **Wrap search.** LFSR[1:0]=3, `lane_full`=4'b1000 → grant lane 0 (4'b0001).
5. **Grant timeout.** Never acknowledge → `lane_random` clears after 64 Clks, `level` and spawn count unchanged, back to WAIT.
6. **Game over and floor.** `gameover_ctrl`=1 during GRANT → `lane_random`=0, `q_Halt`=1 next Clk; then `play_flag`=0, `gameover_ctrl`=0 → IDLE, `level`=0. Separately, force `level`=7 → `interval`=3 (floor, no wrap).

Source files
------------

// File: rtl/nexys_starship_spawn_ctrl_if.sv
// Lane handshake bundle between the spawn scheduler and the four monster lanes.
//   lane_random : one-hot spawn grant, driven by the scheduler (master)
//   lane_full   : per-lane monster-present flags, driven by the lanes (slave)
interface nexys_starship_spawn_ctrl_if;
  logic [3:0] lane_random;
  logic [3:0] lane_full;

  modport master (output lane_random, input lane_full);
  modport slave  (input lane_random, output lane_full);
endinterface

// File: rtl/nexys_starship_spawn_ctrl.sv
// Spawn scheduler for the four monster lanes (0=left, 1=right, 2=top, 3=bottom).
// Paces spawn attempts on timer_tick, picks a pseudo-random empty lane, caps the
// number of concurrent monsters by level and raises the level as spawns land.
// Ports:
//   Clk, Reset (async, active-low)
//   timer_tick     : one-Clk pulse at game timer rate
//   play_flag      : game start request
//   gameover_ctrl  : game over from the top level
//   lanes          : lane_random (one-hot grant out), lane_full (occupancy in)
//   level          : current difficulty level
//   active_count   : number of occupied lanes
//   q_Idle/q_Wait/q_Grant/q_Halt : one-hot state indicators
module nexys_starship_spawn_ctrl #(
  parameter logic [15:0] LFSR_SEED        = 16'hACE1,
  parameter int unsigned BASE_INTERVAL    = 8,
  parameter int unsigned MIN_INTERVAL     = 3,
  parameter int unsigned INTERVAL_STEP    = 1,
  parameter int unsigned SPAWNS_PER_LEVEL = 6,
  parameter int unsigned MAX_LEVEL        = 7,
  parameter int unsigned GRANT_TIMEOUT    = 64
) (
  input  logic                               Clk,
  input  logic                               Reset,
  input  logic                               timer_tick,
  input  logic                               play_flag,
  input  logic                               gameover_ctrl,
  nexys_starship_spawn_ctrl_if.master        lanes,
  output logic [3:0]                         level,
  output logic [2:0]                         active_count,
  output logic                               q_Idle,
  output logic                               q_Wait,
  output logic                               q_Grant,
  output logic                               q_Halt
);

  localparam int unsigned LVL_W  = 4;
  localparam int unsigned ICNT_W = 8;
  localparam int unsigned SCNT_W = $clog2(SPAWNS_PER_LEVEL + 1);
  localparam int unsigned GT_W   = $clog2(GRANT_TIMEOUT + 1);
  // Galois mask for x^16 + x^14 + x^13 + x^11 (right-shifting form)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // One-hot encoding so the state flops drive the q_* indicators directly
  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_WAIT  = 4'b0010,
    S_GRANT = 4'b0100,
    S_HALT  = 4'b1000
  } state_t;

  state_t            state_q;
  logic [3:0]        lane_random_q;
  logic [1:0]        lane_q;
  logic [15:0]       lfsr_q;
  logic [ICNT_W-1:0] icnt_q;
  logic [SCNT_W-1:0] scnt_q;
  logic [GT_W-1:0]   gtmr_q;

  logic [2:0]        active_c;
  logic [2:0]        max_active_c;
  logic [ICNT_W-1:0] interval_c;
  logic [31:0]       dec_c;
  logic [15:0]       lfsr_adv_c;
  logic              pick_found_c;
  logic [1:0]        pick_lane_c;
  logic [1:0]        probe_c;

  assign lanes.lane_random = lane_random_q;
  assign q_Idle  = state_q[0];
  assign q_Wait  = state_q[1];
  assign q_Grant = state_q[2];
  assign q_Halt  = state_q[3];

  // Occupancy, concurrency cap and level-dependent spawn interval
  always_comb begin : derive
    active_c = 3'd0;
    for (int i = 0; i < 4; i++) begin
      active_c = active_c + 3'(lanes.lane_full[i]);
    end
    max_active_c = (level >= 4'd3) ? 3'd4 : 3'(level + 4'd1);
    dec_c        = 32'(level) * INTERVAL_STEP;
    // Saturate at the floor instead of letting the subtraction wrap
    interval_c   = ((dec_c + MIN_INTERVAL) >= BASE_INTERVAL) ? ICNT_W'(MIN_INTERVAL)
                                                              : ICNT_W'(BASE_INTERVAL - dec_c);
    lfsr_adv_c   = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
  end

  // First empty lane starting at the random candidate, wrapping mod 4
  always_comb begin : pick
    pick_found_c = 1'b0;
    pick_lane_c  = 2'd0;
    probe_c      = 2'd0;
    for (int k = 0; k < 4; k++) begin
      probe_c = lfsr_q[1:0] + 2'(k);
      if (!pick_found_c && !lanes.lane_full[probe_c]) begin
        pick_found_c = 1'b1;
        pick_lane_c  = probe_c;
      end
    end
  end

  // Scheduler state machine with registered outputs
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q       <= S_IDLE;
      lane_random_q <= 4'd0;
      lane_q        <= 2'd0;
      level         <= '0;
      active_count  <= 3'd0;
      lfsr_q        <= LFSR_SEED;
      icnt_q        <= '0;
      scnt_q        <= '0;
      gtmr_q        <= '0;
    end else begin
      active_count <= active_c;

      // Free-running outside IDLE; a zero value would lock up, so reseed it
      if (state_q != S_IDLE) begin
        lfsr_q <= (lfsr_q == 16'd0) ? LFSR_SEED : lfsr_adv_c;
      end

      case (state_q)
        S_IDLE: begin
          lane_random_q <= 4'd0;
          level         <= '0;
          icnt_q        <= '0;
          scnt_q        <= '0;
          gtmr_q        <= '0;
          if (play_flag) begin
            state_q <= S_WAIT;
          end
        end

        S_WAIT: begin
          lane_random_q <= 4'd0;
          if (gameover_ctrl) begin
            state_q <= S_HALT;
          end else if (timer_tick) begin
            if ((icnt_q + ICNT_W'(1)) == interval_c) begin
              icnt_q <= '0;
              // A failed pick just skips this attempt
              if (pick_found_c && (active_c < max_active_c)) begin
                lane_q        <= pick_lane_c;
                lane_random_q <= 4'b0001 << pick_lane_c;
                gtmr_q        <= '0;
                state_q       <= S_GRANT;
              end
            end else begin
              icnt_q <= icnt_q + ICNT_W'(1);
            end
          end
        end

        S_GRANT: begin
          if (gameover_ctrl) begin
            lane_random_q <= 4'd0;
            state_q       <= S_HALT;
          end else if (lanes.lane_full[lane_q]) begin
            lane_random_q <= 4'd0;
            state_q       <= S_WAIT;
            if (scnt_q == SCNT_W'(SPAWNS_PER_LEVEL - 1)) begin
              scnt_q <= '0;
              if (level < LVL_W'(MAX_LEVEL)) begin
                level <= level + LVL_W'(1);
              end
            end else begin
              scnt_q <= scnt_q + SCNT_W'(1);
            end
          end else if (gtmr_q == GT_W'(GRANT_TIMEOUT - 1)) begin
            // Lane never took the grant; abandon it without counting a spawn
            lane_random_q <= 4'd0;
            state_q       <= S_WAIT;
          end else begin
            gtmr_q <= gtmr_q + GT_W'(1);
          end
        end

        S_HALT: begin
          lane_random_q <= 4'd0;
          if (!play_flag && !gameover_ctrl) begin
            state_q <= S_IDLE;
            level   <= '0;
            icnt_q  <= '0;
            scnt_q  <= '0;
            gtmr_q  <= '0;
          end
        end

        default: begin
          lane_random_q <= 4'd0;
          state_q       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nexys_starship_spawn_ctrl.sv
// Self-checking bench for nexys_starship_spawn_ctrl: directed scenarios followed
// by randomized play, every cycle compared against a behavioural model.
module tb_nexys_starship_spawn_ctrl;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam int BASE = 8, MINI = 3, STEP = 1, SPL = 6, MAXL = 7, TMO = 64;
  localparam int M_IDLE = 0, M_WAIT = 1, M_GRANT = 2, M_HALT = 3;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       timer_tick, play_flag, gameover_ctrl;
  logic [3:0] level;
  logic [2:0] active_count;
  logic       q_Idle, q_Wait, q_Grant, q_Halt;

  nexys_starship_spawn_ctrl_if lanes ();

  nexys_starship_spawn_ctrl dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .timer_tick    (timer_tick),
    .play_flag     (play_flag),
    .gameover_ctrl (gameover_ctrl),
    .lanes         (lanes),
    .level         (level),
    .active_count  (active_count),
    .q_Idle        (q_Idle),
    .q_Wait        (q_Wait),
    .q_Grant       (q_Grant),
    .q_Halt        (q_Halt)
  );

  always #5 Clk = ~Clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int          m_mode, m_level, m_icnt, m_spawns, m_gt, m_lane, m_active;
  logic [15:0] m_lfsr;
  logic [3:0]  m_grant;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int spec_interval(input int lvl);
    int v;
    v = BASE - lvl * STEP;
    return (v < MINI) ? MINI : v;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_level = 0; m_icnt = 0; m_spawns = 0; m_gt = 0;
    m_lane = 0; m_active = 0; m_lfsr = SEED; m_grant = 4'd0;
  endtask

  // Predicts the state after the coming rising edge from the current inputs
  task automatic model_step();
    int ac, maxa, intv, lf, idx, pick;
    logic [15:0] nl;
    lf   = int'(lanes.lane_full);
    ac   = $countones(lanes.lane_full);
    maxa = (m_level + 1 < 4) ? m_level + 1 : 4;
    intv = spec_interval(m_level);
    nl   = m_lfsr;
    if (m_mode != M_IDLE) nl = (m_lfsr == 16'h0) ? SEED : lfsr_next(m_lfsr);
    case (m_mode)
      M_IDLE: begin
        m_level = 0; m_icnt = 0; m_spawns = 0; m_grant = 4'd0;
        if (play_flag) m_mode = M_WAIT;
      end
      M_WAIT: begin
        if (gameover_ctrl) m_mode = M_HALT;
        else if (timer_tick) begin
          if (m_icnt + 1 == intv) begin
            m_icnt = 0;
            pick = -1;
            for (int k = 3; k >= 0; k--) begin
              idx = (int'(m_lfsr[1:0]) + k) % 4;
              if (((lf >> idx) & 1) == 0) pick = idx;
            end
            if (pick >= 0 && ac < maxa) begin
              m_lane = pick; m_grant = 4'(1 << pick); m_gt = 0; m_mode = M_GRANT;
            end
          end else m_icnt++;
        end
      end
      M_GRANT: begin
        if (gameover_ctrl) begin
          m_grant = 4'd0; m_mode = M_HALT;
        end else if (((lf >> m_lane) & 1) == 1) begin
          m_grant = 4'd0; m_mode = M_WAIT; m_spawns++;
          if (m_spawns == SPL) begin
            m_spawns = 0;
            if (m_level < MAXL) m_level++;
          end
        end else if (m_gt == TMO - 1) begin
          m_grant = 4'd0; m_mode = M_WAIT;
        end else m_gt++;
      end
      default: begin
        m_grant = 4'd0;
        if (!play_flag && !gameover_ctrl) begin
          m_mode = M_IDLE; m_level = 0; m_icnt = 0; m_spawns = 0;
        end
      end
    endcase
    m_active = ac;
    m_lfsr   = nl;
  endtask

  task automatic compare_all();
    check("lane_random", 32'(lanes.lane_random), 32'(m_grant));
    check("level", 32'(level), 32'(m_level));
    check("active_count", 32'(active_count), 32'(m_active));
    check("state_onehot", 32'({q_Halt, q_Grant, q_Wait, q_Idle}), 32'(1 << m_mode));
  endtask

  // One clock: model predicts, DUT clocks, compare at the falling edge
  task automatic cycle();
    model_step();
    @(posedge Clk);
    @(negedge Clk);
    compare_all();
  endtask

  task automatic pulse_tick();
    timer_tick = 1'b1; cycle();
    timer_tick = 1'b0; cycle();
  endtask

  // Ticks until a grant appears, acknowledges it, then empties the lanes
  task automatic do_spawn(output int ticks);
    ticks = 0;
    while (lanes.lane_random == 4'd0 && ticks < 40) begin
      pulse_tick();
      ticks++;
    end
    check("grant_seen", 32'(lanes.lane_random != 4'd0), 32'd1);
    lanes.lane_full = lanes.lane_random; cycle();
    check("ack_clears", 32'(lanes.lane_random), 32'd0);
    lanes.lane_full = 4'd0; cycle();
  endtask

  task automatic apply_reset();
    Reset = 1'b0;
    model_reset();
    @(negedge Clk);
    @(negedge Clk);
    compare_all();
    Reset = 1'b1;
  endtask

  initial begin
    int t, n, bound;
    Reset = 1'b0; timer_tick = 1'b0; play_flag = 1'b0; gameover_ctrl = 1'b0;
    lanes.lane_full = 4'd0;
    apply_reset();
    check("reset_idle", 32'(q_Idle), 32'd1);

    // Start: play_flag moves to WAIT
    play_flag = 1'b1; cycle(); play_flag = 1'b0;
    check("start_wait", 32'(q_Wait), 32'd1);

    // Level 0 cap: one lane occupied means the attempt is skipped
    lanes.lane_full = 4'b0001;
    for (int i = 0; i < 8; i++) pulse_tick();
    check("cap_skip_l0", 32'(lanes.lane_random), 32'd0);
    lanes.lane_full = 4'b0000; cycle();

    // First grant after exactly 8 ticks, acked 3 Clks later
    t = 0;
    while (lanes.lane_random == 4'd0 && t < 40) begin pulse_tick(); t++; end
    check("first_grant_ticks", 32'(t), 32'd8);
    check("first_grant_onehot", 32'($countones(lanes.lane_random)), 32'd1);
    cycle();
    lanes.lane_full = lanes.lane_random; cycle();
    check("ack_3clk_clears", 32'(lanes.lane_random), 32'd0);
    lanes.lane_full = 4'd0; cycle();

    for (int i = 0; i < 5; i++) do_spawn(t);
    check("level_up_1", 32'(level), 32'd1);
    do_spawn(t);
    check("interval_l1", 32'(t), 32'd7);

    // Wrap search: candidate lane 3 is full, so lane 0 gets the grant
    lanes.lane_full = 4'b1000;
    for (int i = 0; i < 6; i++) pulse_tick();
    bound = 0;
    while (m_lfsr[1:0] != 2'd3 && bound < 100) begin cycle(); bound++; end
    timer_tick = 1'b1; cycle(); timer_tick = 1'b0;
    check("wrap_grant", 32'(lanes.lane_random), 32'b0001);

    // Unacknowledged grant is dropped after 64 Clks
    n = 1;
    while (lanes.lane_random != 4'd0 && n < 200) begin
      cycle();
      if (lanes.lane_random != 4'd0) n++;
    end
    check("timeout_cycles", 32'(n), 32'd64);
    check("timeout_level", 32'(level), 32'd1);
    check("timeout_wait", 32'(q_Wait), 32'd1);
    lanes.lane_full = 4'd0; cycle();

    // Timed-out grant must not count: 5 more spawns finish level 1
    for (int i = 0; i < 5; i++) do_spawn(t);
    check("level_up_2", 32'(level), 32'd2);

    bound = 0;
    while (level < 4'd3 && bound < 20) begin do_spawn(t); bound++; end
    lanes.lane_full = 4'b1111;
    for (int i = 0; i < 10; i++) pulse_tick();
    check("all_full_l3", 32'(lanes.lane_random), 32'd0);
    lanes.lane_full = 4'd0; cycle();

    // Interval floor at the top level, and level saturation
    bound = 0;
    while (level < 4'd7 && bound < 60) begin do_spawn(t); bound++; end
    do_spawn(t);
    check("interval_floor", 32'(t), 32'd3);
    for (int i = 0; i < 6; i++) do_spawn(t);
    check("level_saturate", 32'(level), 32'd7);

    // Game over during a grant, then back to IDLE
    t = 0;
    while (lanes.lane_random == 4'd0 && t < 40) begin pulse_tick(); t++; end
    gameover_ctrl = 1'b1; cycle();
    check("halt_clears_grant", 32'(lanes.lane_random), 32'd0);
    check("halt_state", 32'(q_Halt), 32'd1);
    gameover_ctrl = 1'b0; cycle();
    check("halt_to_idle", 32'(q_Idle), 32'd1);
    check("idle_level", 32'(level), 32'd0);

    // Asynchronous reset while a grant is outstanding
    play_flag = 1'b1; cycle(); play_flag = 1'b0;
    t = 0;
    while (lanes.lane_random == 4'd0 && t < 40) begin pulse_tick(); t++; end
    #2 Reset = 1'b0;
    #1;
    check("async_rst_grant", 32'(lanes.lane_random), 32'd0);
    check("async_rst_idle", 32'(q_Idle), 32'd1);
    model_reset();
    @(negedge Clk);
    compare_all();
    Reset = 1'b1;

    // Randomized play
    for (int c = 0; c < 4000; c++) begin
      timer_tick    = ($urandom_range(0, 3) == 0);
      play_flag     = ($urandom_range(0, 7) == 0);
      gameover_ctrl = ($urandom_range(0, 149) == 0);
      if (m_grant != 4'd0 && $urandom_range(0, 5) == 0) lanes.lane_full = lanes.lane_full | m_grant;
      if ($urandom_range(0, 9) == 0) lanes.lane_full = lanes.lane_full & ~(4'b0001 << $urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) lanes.lane_full = lanes.lane_full | (4'b0001 << $urandom_range(0, 3));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
